// File: rtl/stream_demux_param.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_param
// Purpose  : Registered 1-to-N_CH stream demultiplexer. One valid/ready input
//            beat is steered by in_sel into a one-entry register slot per
//            output channel. Each channel drains on its own out_ready.
//            Out-of-range destinations are accepted and discarded.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            enable                - low stalls the input (in_ready = 0)
//            in_valid/in_ready     - input handshake (in_ready combinational)
//            in_sel, in_data       - destination index and payload
//            out_valid/out_ready   - per-channel handshake (N_CH bits)
//            out_data              - channel k at [k*DATA_W +: DATA_W]
//            drop_cnt              - saturating count of discarded beats
// Options  : STREAM_DEMUX_DROP_CNT_EN - builds the drop_cnt port and counter
// Revision : 1.0 - initial release
// ============================================================================
module stream_demux_param #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2,
  parameter int N_CH   = 2**SEL_W,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [DATA_W-1:0]        in_data,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH*DATA_W-1:0]   out_data
`ifdef STREAM_DEMUX_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0]         drop_cnt
`endif
);

  // Channel count in a width that holds N_CH itself (up to 2**SEL_W).
  localparam logic [SEL_W:0] N_CH_L = (SEL_W+1)'(N_CH);

  logic            in_range;
  logic            sel_can_take;
  logic            accept;
  logic [N_CH-1:0] sel_hit;
  logic [N_CH-1:0] can_take;

  assign in_range = ({1'b0, in_sel} < N_CH_L);

  // One-hot select gating avoids a variable index that could run past N_CH.
  assign sel_can_take = |(sel_hit & can_take);

  // Out-of-range beats never block: they are swallowed whenever enabled.
  assign in_ready = enable && (!in_range || sel_can_take);
  assign accept   = in_valid && in_ready;

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic              valid_q;
      logic [DATA_W-1:0] data_q;

      assign sel_hit[k]  = (in_sel == SEL_W'(k));
      // A FULL slot being drained this cycle can be refilled in the same cycle.
      assign can_take[k] = !valid_q || out_ready[k];

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else if (accept && sel_hit[k]) begin
          valid_q <= 1'b1;
          data_q  <= in_data;
        end else if (out_ready[k]) begin
          valid_q <= 1'b0;
        end
      end

      assign out_valid[k]                  = valid_q;
      assign out_data[k*DATA_W +: DATA_W]  = data_q;
    end
  endgenerate

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [CNT_W-1:0] drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (accept && !in_range && (drop_q != {CNT_W{1'b1}})) begin
      drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule
`default_nettype wire
